// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer sequencer.
// State encoding and CS timing defaults reused by other SPI peripherals.
package spi_xfer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_RX = 3'd4,
    ST_GAP     = 3'd5,
    ST_HOLD    = 3'd6,
    ST_CS_IDLE = 3'd7
  } state_e;

  localparam int DEF_CS_SETUP_CLKS = 2;
  localparam int DEF_CS_HOLD_CLKS  = 2;
  localparam int DEF_CS_IDLE_CLKS  = 4;
  localparam int DEF_GAP_CLKS      = 0;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = max4(a, b, c, d);
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_timer.sv
// Loadable down-counter with terminal-count flag.
// Shared by the CS setup, byte gap, CS hold and CS idle phases.
module spi_delay_timer #(
  parameter int CNT_W = 3
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_Count,
  output logic             o_Tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q <= '0;
    end else if (i_Load) begin
      cnt_q <= i_Count;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Terminal on the last cycle of a phase loaded with N
  assign o_Tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transaction sequencer in front of SPI_Master.
// Owns chip select timing and streams bytes one at a time.
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int LEN_W         = 8,
  parameter int CS_SETUP_CLKS = DEF_CS_SETUP_CLKS,
  parameter int CS_HOLD_CLKS  = DEF_CS_HOLD_CLKS,
  parameter int CS_IDLE_CLKS  = DEF_CS_IDLE_CLKS,
  parameter int GAP_CLKS      = DEF_GAP_CLKS
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [LEN_W-1:0] i_Len,
  output logic             o_Busy,
  output logic             o_Done,
  input  logic [7:0]       i_TX_Byte,
  input  logic             i_TX_Valid,
  output logic             o_TX_Ready,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  output logic             o_RX_Last,
  output logic [7:0]       o_M_TX_Byte,
  output logic             o_M_TX_DV,
  input  logic             i_M_TX_Ready,
  input  logic             i_M_RX_DV,
  input  logic [7:0]       i_M_RX_Byte,
  output logic             o_SPI_CS_n
);

  localparam int CNT_W = cnt_width(
    CS_SETUP_CLKS, CS_HOLD_CLKS,
    CS_IDLE_CLKS, GAP_CLKS);

  // The LOAD cycle itself counts toward setup time
  localparam logic [CNT_W-1:0] SETUP_LD =
    CNT_W'(CS_SETUP_CLKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(CS_HOLD_CLKS);
  localparam logic [CNT_W-1:0] IDLE_LD =
    CNT_W'(CS_IDLE_CLKS);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'(GAP_CLKS);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rx_dv_q, rx_dv_d;
  logic             rx_last_q, rx_last_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [7:0]       m_byte_q, m_byte_d;
  logic             m_dv_q, m_dv_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;
  logic             tx_ready;
  logic             last_byte;

  spi_delay_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Load (tmr_load),
    .i_Count(tmr_val),
    .o_Tc   (tmr_tc)
  );

  assign tx_ready  = (state_q == ST_LOAD) & i_M_TX_Ready;
  assign last_byte = (rem_q == '0);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_dv_d   = 1'b0;
    rx_last_d = 1'b0;
    rx_byte_d = rx_byte_q;
    m_byte_d  = m_byte_q;
    m_dv_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          rem_d  = i_Len;
          cs_n_d = 1'b0;
          busy_d = 1'b1;
          if (SETUP_LD != '0) begin
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_tc) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (i_TX_Valid && tx_ready) begin
          m_byte_d = i_TX_Byte;
          m_dv_d   = 1'b1;
          state_d  = ST_SEND;
        end
      end
      // Lets SPI_Master drop its ready before we listen
      ST_SEND: begin
        state_d = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        if (i_M_RX_DV) begin
          rx_byte_d = i_M_RX_Byte;
          rx_dv_d   = 1'b1;
          rx_last_d = last_byte;
          if (last_byte) begin
            state_d  = ST_HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else begin
            rem_d = rem_q - LEN_W'(1);
            if (GAP_CLKS > 0) begin
              state_d  = ST_GAP;
              tmr_load = 1'b1;
              tmr_val  = GAP_LD;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_GAP: begin
        if (tmr_tc) state_d = ST_LOAD;
      end
      ST_HOLD: begin
        if (tmr_tc) begin
          cs_n_d   = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_CS_IDLE;
          tmr_load = 1'b1;
          tmr_val  = IDLE_LD;
        end
      end
      ST_CS_IDLE: begin
        if (tmr_tc) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_dv_q   <= 1'b0;
      rx_last_q <= 1'b0;
      rx_byte_q <= 8'h00;
      m_byte_q  <= 8'h00;
      m_dv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_dv_q   <= rx_dv_d;
      rx_last_q <= rx_last_d;
      rx_byte_q <= rx_byte_d;
      m_byte_q  <= m_byte_d;
      m_dv_q    <= m_dv_d;
    end
  end

  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_TX_Ready  = tx_ready;
  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_RX_Last   = rx_last_q;
  assign o_M_TX_Byte = m_byte_q;
  assign o_M_TX_DV   = m_dv_q;
  assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl with a loopback SPI_Master stand-in.
// Instance 0 uses defaults, instance 1 uses a 3-cycle byte gap.
module tb_spi_xfer_ctrl;

  localparam int LAT   = 34;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int IDLE  = 4;
  localparam int LIM   = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      start;
  logic [1:0][7:0] len;
  logic [1:0]      busy, done, txv, txr;
  logic [1:0][7:0] txb, rxb, mtxb, mrxb, sh;
  logic [1:0]      rxdv, rxl, mtxdv, mrdy, mrxdv, csn;
  int              mcnt [2];
  int              cyc = 0;
  int              n_chk = 0;
  int              n_err = 0;
  bit              rnd_gap = 0;

  logic [7:0] txq0[$], txq1[$];
  int fall_q[$], rise_q[$], mdv_q[$];
  int done_q[$], bf_q[$], rxt_q[$];
  logic [7:0] rxb_q[$];
  logic rxl_q[$];
  int mdv1_q[$];
  logic [7:0] rxb1_q[$];
  logic rxl1_q[$];
  int done1_n = 0;
  int bad_rdy = 0;
  logic cs_p = 1'b1;
  logic bz_p = 1'b0;

  spi_xfer_ctrl u_dut0 (
    .i_Clk(clk), .i_Rst(rst),
    .i_Start(start[0]), .i_Len(len[0]),
    .o_Busy(busy[0]), .o_Done(done[0]),
    .i_TX_Byte(txb[0]), .i_TX_Valid(txv[0]),
    .o_TX_Ready(txr[0]), .o_RX_DV(rxdv[0]),
    .o_RX_Byte(rxb[0]), .o_RX_Last(rxl[0]),
    .o_M_TX_Byte(mtxb[0]), .o_M_TX_DV(mtxdv[0]),
    .i_M_TX_Ready(mrdy[0]), .i_M_RX_DV(mrxdv[0]),
    .i_M_RX_Byte(mrxb[0]), .o_SPI_CS_n(csn[0])
  );

  spi_xfer_ctrl #(.GAP_CLKS(3)) u_dut1 (
    .i_Clk(clk), .i_Rst(rst),
    .i_Start(start[1]), .i_Len(len[1]),
    .o_Busy(busy[1]), .o_Done(done[1]),
    .i_TX_Byte(txb[1]), .i_TX_Valid(txv[1]),
    .o_TX_Ready(txr[1]), .o_RX_DV(rxdv[1]),
    .o_RX_Byte(rxb[1]), .o_RX_Last(rxl[1]),
    .o_M_TX_Byte(mtxb[1]), .o_M_TX_DV(mtxdv[1]),
    .i_M_TX_Ready(mrdy[1]), .i_M_RX_DV(mrxdv[1]),
    .i_M_RX_Byte(mrxb[1]), .o_SPI_CS_n(csn[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // SPI_Master stand-in: fixed latency, MISO looped to MOSI
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mrdy[k]  <= 1'b1;
        mrxdv[k] <= 1'b0;
        mrxb[k]  <= 8'h00;
        mcnt[k]  <= 0;
      end else begin
        mrxdv[k] <= 1'b0;
        if (mtxdv[k] && mrdy[k]) begin
          mrdy[k] <= 1'b0;
          mcnt[k] <= LAT;
          sh[k]   <= mtxb[k];
        end else if (mcnt[k] > 1) begin
          mcnt[k] <= mcnt[k] - 1;
        end else if (mcnt[k] == 1) begin
          mcnt[k]  <= 0;
          mrxdv[k] <= 1'b1;
          mrxb[k]  <= sh[k];
          mrdy[k]  <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (txv[0] && txr[0] && txq0.size() > 0)
      void'(txq0.pop_front());
    if (txv[1] && txr[1] && txq1.size() > 0)
      void'(txq1.pop_front());
  end

  always @(negedge clk) begin
    txv[0] = (txq0.size() > 0) &&
             (!rnd_gap || $urandom_range(0, 3) != 0);
    txb[0] = (txq0.size() > 0) ? txq0[0] : 8'h00;
    txv[1] = (txq1.size() > 0);
    txb[1] = (txq1.size() > 0) ? txq1[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (cs_p && !csn[0]) fall_q.push_back(cyc);
    if (!cs_p && csn[0]) rise_q.push_back(cyc);
    if (bz_p && !busy[0]) bf_q.push_back(cyc);
    if (mtxdv[0]) mdv_q.push_back(cyc);
    if (done[0]) done_q.push_back(cyc);
    if (rxdv[0]) begin
      rxt_q.push_back(cyc);
      rxb_q.push_back(rxb[0]);
      rxl_q.push_back(rxl[0]);
    end
    if (txr[0] && csn[0]) bad_rdy++;
    if (mtxdv[1]) mdv1_q.push_back(cyc);
    if (rxdv[1]) begin
      rxb1_q.push_back(rxb[1]);
      rxl1_q.push_back(rxl[1]);
    end
    if (done[1]) done1_n++;
    cs_p = csn[0];
    bz_p = busy[0];
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    fall_q.delete(); rise_q.delete(); mdv_q.delete();
    done_q.delete(); bf_q.delete(); rxt_q.delete();
    rxb_q.delete(); rxl_q.delete();
    mdv1_q.delete(); rxb1_q.delete(); rxl1_q.delete();
    done1_n = 0;
  endtask

  task automatic pulse_start(
    input logic [1:0] m,
    input logic [7:0] l,
    output int a
  );
    @(negedge clk);
    start = m;
    len = {l, l};
    @(negedge clk);
    a = cyc;
    start = '0;
    #1;
  endtask

  task automatic wait_idle(output bit to);
    int n;
    for (n = 0; n < LIM && bf_q.size() == 0; n++) tick(1);
    to = (bf_q.size() == 0);
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_chk++; if (csn[0] !== 1'b1) begin n_err++; $display("FAIL rst_cs got=%b exp=1", csn[0]); end
    n_chk++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
    n_chk++; if (done[0] !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done[0]); end
    n_chk++; if (txr[0] !== 1'b0) begin n_err++; $display("FAIL rst_txrdy got=%b exp=0", txr[0]); end
    n_chk++; if (rxdv[0] !== 1'b0) begin n_err++; $display("FAIL rst_rxdv got=%b exp=0", rxdv[0]); end
    n_chk++; if (rxl[0] !== 1'b0) begin n_err++; $display("FAIL rst_rxlast got=%b exp=0", rxl[0]); end
    n_chk++; if (rxb[0] !== 8'h00) begin n_err++; $display("FAIL rst_rxbyte got=%h exp=00", rxb[0]); end
    n_chk++; if (mtxb[0] !== 8'h00) begin n_err++; $display("FAIL rst_mtxbyte got=%h exp=00", mtxb[0]); end
    n_chk++; if (mtxdv[0] !== 1'b0) begin n_err++; $display("FAIL rst_mtxdv got=%b exp=0", mtxdv[0]); end
    rst = 1'b0;
    tick(3);
    clear_mon();
  endtask

  task automatic test_single();
    int a, f, r, t;
    bit to;
    clear_mon();
    txq0.push_back(8'hA5);
    pulse_start(2'b01, 8'd0, a);
    wait_idle(to);
    f = fall_q.size() ? fall_q[0] : -1;
    r = rise_q.size() ? rise_q[0] : -1;
    t = rxt_q.size() ? rxt_q[0] : -1;
    n_chk++; if (to) begin n_err++; $display("FAIL single_timeout got=stuck exp=idle"); end
    n_chk++; if (f !== a) begin n_err++; $display("FAIL single_csfall got=%0d exp=%0d", f, a); end
    n_chk++; if (mdv_q.size() !== 1 || mdv_q[0] !== f + SETUP) begin n_err++; $display("FAIL single_mdv n=%0d exp_t=%0d", mdv_q.size(), f + SETUP); end
    n_chk++; if (rxb_q.size() !== 1 || rxb_q[0] !== 8'hA5 || rxl_q[0] !== 1'b1) begin n_err++; $display("FAIL single_rx n=%0d exp=A5 last", rxb_q.size()); end
    n_chk++; if (r !== t + HOLD) begin n_err++; $display("FAIL single_csrise got=%0d exp=%0d", r, t + HOLD); end
    n_chk++; if (done_q.size() !== 1 || done_q[0] !== r) begin n_err++; $display("FAIL single_done n=%0d exp_t=%0d", done_q.size(), r); end
    n_chk++; if (bf_q.size() !== 1 || bf_q[0] !== r + IDLE) begin n_err++; $display("FAIL single_busy n=%0d exp_t=%0d", bf_q.size(), r + IDLE); end
  endtask

  task automatic test_burst();
    int a;
    bit to;
    logic [7:0] exp_b [4];
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      exp_b[i] = 8'(i + 1);
      txq0.push_back(exp_b[i]);
    end
    pulse_start(2'b01, 8'd3, a);
    wait_idle(to);
    n_chk++; if (to) begin n_err++; $display("FAIL burst_timeout got=stuck exp=idle"); end
    n_chk++; if (rxb_q.size() !== 4) begin n_err++; $display("FAIL burst_rxcount got=%0d exp=4", rxb_q.size()); end
    for (int i = 0; i < 4 && i < rxb_q.size(); i++) begin
      n_chk++; if (rxb_q[i] !== exp_b[i] || rxl_q[i] !== (i == 3)) begin n_err++; $display("FAIL burst_rx%0d got=%h/%b exp=%h/%b", i, rxb_q[i], rxl_q[i], exp_b[i], i == 3); end
    end
    n_chk++; if (mdv_q.size() !== 4) begin n_err++; $display("FAIL burst_mdv got=%0d exp=4", mdv_q.size()); end
    n_chk++; if (fall_q.size() !== 1 || rise_q.size() !== 1) begin n_err++; $display("FAIL burst_cs falls=%0d rises=%0d exp=1/1", fall_q.size(), rise_q.size()); end
    n_chk++; if (done_q.size() !== 1) begin n_err++; $display("FAIL burst_done got=%0d exp=1", done_q.size()); end
  endtask

  task automatic test_underflow();
    int a, n;
    bit to;
    clear_mon();
    txq0.push_back(8'h3C);
    pulse_start(2'b01, 8'd1, a);
    for (n = 0; n < LIM && (mdv_q.size() == 0 || txq0.size() != 0); n++) tick(1);
    tick(50);
    n_chk++; if (csn[0] !== 1'b0 || rise_q.size() !== 0) begin n_err++; $display("FAIL uflow_cs got=%b rises=%0d exp=0/0", csn[0], rise_q.size()); end
    n_chk++; if (mdv_q.size() !== 1 || rxb_q.size() !== 1) begin n_err++; $display("FAIL uflow_stall mdv=%0d rx=%0d exp=1/1", mdv_q.size(), rxb_q.size()); end
    txq0.push_back(8'hC3);
    wait_idle(to);
    n_chk++; if (to) begin n_err++; $display("FAIL uflow_timeout got=stuck exp=idle"); end
    n_chk++; if (rxb_q.size() !== 2 || rxb_q[0] !== 8'h3C || rxb_q[1] !== 8'hC3) begin n_err++; $display("FAIL uflow_rx n=%0d exp=3C,C3", rxb_q.size()); end
    n_chk++; if (rxl_q.size() !== 2 || rxl_q[0] !== 1'b0 || rxl_q[1] !== 1'b1) begin n_err++; $display("FAIL uflow_last n=%0d exp=0,1", rxl_q.size()); end
    n_chk++; if (mdv_q.size() !== 2 || fall_q.size() !== 1) begin n_err++; $display("FAIL uflow_dv mdv=%0d falls=%0d exp=2/1", mdv_q.size(), fall_q.size()); end
  endtask

  task automatic test_busy_reject();
    int a, d, n;
    bit to;
    clear_mon();
    txq0.push_back(8'h11);
    txq0.push_back(8'h22);
    pulse_start(2'b01, 8'd1, a);
    for (n = 0; n < LIM && mdv_q.size() == 0; n++) tick(1);
    pulse_start(2'b01, 8'd5, d);
    for (n = 0; n < LIM && done_q.size() == 0; n++) tick(1);
    n_chk++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL rej_idlebusy got=%b exp=1", busy[0]); end
    pulse_start(2'b01, 8'd0, d);
    wait_idle(to);
    tick(10);
    n_chk++; if (to) begin n_err++; $display("FAIL rej_timeout got=stuck exp=idle"); end
    n_chk++; if (fall_q.size() !== 1 || done_q.size() !== 1) begin n_err++; $display("FAIL rej_extra falls=%0d dones=%0d exp=1/1", fall_q.size(), done_q.size()); end
    n_chk++; if (rxb_q.size() !== 2 || rxb_q[1] !== 8'h22 || rxl_q[1] !== 1'b1) begin n_err++; $display("FAIL rej_rx n=%0d exp=2 ending 22", rxb_q.size()); end
    n_chk++; if (csn[0] !== 1'b1 || busy[0] !== 1'b0) begin n_err++; $display("FAIL rej_after cs=%b busy=%b exp=1/0", csn[0], busy[0]); end
    clear_mon();
    txq0.push_back(8'h5A);
    pulse_start(2'b01, 8'd0, a);
    wait_idle(to);
    n_chk++; if (fall_q.size() !== 1 || fall_q[0] !== a) begin n_err++; $display("FAIL rej_next n=%0d exp_t=%0d", fall_q.size(), a); end
    n_chk++; if (rxb_q.size() !== 1 || rxb_q[0] !== 8'h5A) begin n_err++; $display("FAIL rej_nextrx n=%0d exp=5A", rxb_q.size()); end
  endtask

  task automatic test_reset_mid();
    int a, n;
    bit to;
    clear_mon();
    for (int i = 0; i < 8; i++) txq0.push_back(8'($urandom));
    pulse_start(2'b01, 8'd7, a);
    for (n = 0; n < LIM && mdv_q.size() < 3; n++) tick(1);
    rst = 1'b1;
    tick(1);
    n_chk++; if (csn[0] !== 1'b1 || busy[0] !== 1'b0) begin n_err++; $display("FAIL midrst_cs cs=%b busy=%b exp=1/0", csn[0], busy[0]); end
    n_chk++; if ({done[0], rxdv[0], rxl[0], mtxdv[0], txr[0]} !== 5'b0) begin n_err++; $display("FAIL midrst_flags got=%b exp=00000", {done[0], rxdv[0], rxl[0], mtxdv[0], txr[0]}); end
    n_chk++; if (rxb[0] !== 8'h00 || mtxb[0] !== 8'h00) begin n_err++; $display("FAIL midrst_bytes rx=%h m=%h exp=00/00", rxb[0], mtxb[0]); end
    rst = 1'b0;
    txq0.delete();
    tick(60);
    n_chk++; if (done_q.size() !== 0 || csn[0] !== 1'b1) begin n_err++; $display("FAIL midrst_done dones=%0d cs=%b exp=0/1", done_q.size(), csn[0]); end
    clear_mon();
    txq0.push_back(8'h77);
    pulse_start(2'b01, 8'd0, a);
    wait_idle(to);
    n_chk++; if (to || rxb_q.size() !== 1 || rxb_q[0] !== 8'h77 || rxl_q[0] !== 1'b1) begin n_err++; $display("FAIL midrst_after n=%0d exp=77 last", rxb_q.size()); end
    n_chk++; if (done_q.size() !== 1) begin n_err++; $display("FAIL midrst_afterdone got=%0d exp=1", done_q.size()); end
  endtask

  task automatic test_gap();
    int a, n, d0, d1;
    clear_mon();
    txq0.push_back(8'hAB); txq0.push_back(8'hCD);
    txq1.push_back(8'hAB); txq1.push_back(8'hCD);
    pulse_start(2'b11, 8'd1, a);
    for (n = 0; n < LIM && (bf_q.size() == 0 || done1_n == 0); n++) tick(1);
    tick(10);
    d0 = (mdv_q.size() == 2) ? mdv_q[1] - mdv_q[0] : -1;
    d1 = (mdv1_q.size() == 2) ? mdv1_q[1] - mdv1_q[0] : -1;
    n_chk++; if (d0 < 0 || !(d1 >= d0 + 3)) begin n_err++; $display("FAIL gap_spacing got=%0d exp>=%0d", d1, d0 + 3); end
    n_chk++; if (rxb1_q.size() !== 2 || rxb1_q[0] !== 8'hAB || rxb1_q[1] !== 8'hCD) begin n_err++; $display("FAIL gap_rx n=%0d exp=AB,CD", rxb1_q.size()); end
    n_chk++; if (rxl1_q.size() !== 2 || rxl1_q[1] !== 1'b1 || rxl1_q[0] !== 1'b0) begin n_err++; $display("FAIL gap_last n=%0d exp=0,1", rxl1_q.size()); end
    n_chk++; if (done1_n !== 1 || csn[1] !== 1'b1 || busy[1] !== 1'b0) begin n_err++; $display("FAIL gap_end done=%0d cs=%b busy=%b exp=1/1/0", done1_n, csn[1], busy[1]); end
  endtask

  task automatic test_random();
    int a, l, r, t;
    bit to;
    logic [7:0] exp_b[$];
    rnd_gap = 1;
    for (int it = 0; it < 6; it++) begin
      clear_mon();
      exp_b.delete();
      l = $urandom_range(0, 6);
      for (int i = 0; i <= l; i++) begin
        exp_b.push_back(8'($urandom));
        txq0.push_back(exp_b[i]);
      end
      pulse_start(2'b01, 8'(l), a);
      wait_idle(to);
      r = rise_q.size() ? rise_q[0] : -1;
      t = rxt_q.size() ? rxt_q[rxt_q.size() - 1] : -1;
      n_chk++; if (to || rxb_q.size() !== l + 1) begin n_err++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, rxb_q.size(), l + 1); end
      for (int i = 0; i <= l && i < rxb_q.size(); i++) begin
        n_chk++; if (rxb_q[i] !== exp_b[i] || rxl_q[i] !== (i == l)) begin n_err++; $display("FAIL rnd%0d_rx%0d got=%h/%b exp=%h/%b", it, i, rxb_q[i], rxl_q[i], exp_b[i], i == l); end
      end
      n_chk++; if (mdv_q.size() !== l + 1 || fall_q.size() !== 1 || mdv_q[0] < fall_q[0] + SETUP) begin n_err++; $display("FAIL rnd%0d_dv mdv=%0d exp=%0d", it, mdv_q.size(), l + 1); end
      n_chk++; if (r !== t + HOLD || done_q.size() !== 1 || bf_q.size() !== 1 || bf_q[0] !== r + IDLE) begin n_err++; $display("FAIL rnd%0d_tail rise=%0d exp=%0d", it, r, t + HOLD); end
      tick($urandom_range(0, 3));
    end
    rnd_gap = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    len = '0;
    test_reset();
    test_single();
    test_burst();
    test_underflow();
    test_busy_reject();
    test_reset_mid();
    test_gap();
    test_random();
    n_chk++; if (bad_rdy !== 0) begin n_err++; $display("FAIL txready_outside got=%0d exp=0", bad_rdy); end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
